// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - multi-cycle multiply/divide unit with HI/LO result registers
// Divider hardware and DIV/DIVU ops are built only when MDU_DIV_EN is defined.
module mdu_hilo #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] res_hi, res_lo;

  // Full-width multiplies; sign extension to 2*WIDTH makes the low half exact for MULT.
  logic [2*WIDTH-1:0] a_sx, b_sx, prod_s, prod_u;
  assign a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

`ifdef MDU_DIV_EN
  logic [WIDTH-1:0] a_mag, b_mag, mag_q, mag_r, sdiv_q, sdiv_r, udiv_q, udiv_r;
  logic             b_zero;
  assign b_zero = (b_q == '0);
  assign a_mag  = a_q[WIDTH-1] ? -a_q : a_q;
  assign b_mag  = b_q[WIDTH-1] ? -b_q : b_q;
  assign mag_q  = b_zero ? '0 : a_mag / b_mag;
  assign mag_r  = b_zero ? '0 : a_mag % b_mag;
  // Most-negative / -1 falls out naturally: the quotient magnitude wraps back to most-negative.
  assign sdiv_q = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -mag_q : mag_q;
  assign sdiv_r = a_q[WIDTH-1] ? -mag_r : mag_r;
  assign udiv_q = b_zero ? '0 : a_q / b_q;
  assign udiv_r = b_zero ? '0 : a_q % b_q;
`endif

  always_comb begin
    res_hi = prod_u[2*WIDTH-1:WIDTH];
    res_lo = prod_u[WIDTH-1:0];
    case (op_q)
      OP_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
`ifdef MDU_DIV_EN
      OP_DIV: begin
        res_hi = b_zero ? a_q : sdiv_r;
        res_lo = b_zero ? '1  : sdiv_q;
      end
      OP_DIVU: begin
        res_hi = b_zero ? a_q : udiv_r;
        res_lo = b_zero ? '1  : udiv_q;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d = RUN;
              cnt_d   = CW'(MULT_LAT);
              op_d    = op;
              a_d     = A;
              b_d     = B;
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              state_d = RUN;
              cnt_d   = CW'(DIV_LAT);
              op_d    = op;
              a_d     = A;
              b_d     = B;
            end
`endif
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - scoreboard bench for mdu_hilo (DIV vectors only with MDU_DIV_EN)
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hi, lo;

  mdu_hilo #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each falling edge of busy is one committed result.
  logic mon_prev = 1'b0;
  int   mon_cnt  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev = 1'b0;
      mon_cnt  = 0;
    end else begin
      if (busy) mon_cnt++;
      else if (mon_prev) begin
        if (sb.size() == 0) chk("unexpected_commit", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_hi", hi, e.hi);
          chk("commit_lo", lo, e.lo);
          chk("busy_cycles", 32'(mon_cnt), 32'(e.lat));
        end
        mon_cnt = 0;
      end
      mon_prev = busy;
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_res(input logic [31:0] h, input logic [31:0] l, input int lat);
    exp_t e;
    e.hi = h; e.lo = l; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'b000; A = '0; B = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);

    issue(3'b100, 32'h12345678, 32'h0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_lo", lo, 32'h0);

    expect_res(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(3'b000, 32'hFFFFFFFE, 32'd3);
    wait_idle();
    expect_res(32'h00000002, 32'hFFFFFFFA, 5);
    issue(3'b001, 32'hFFFFFFFE, 32'd3);
    wait_idle();

    issue(3'b101, 32'hCAFEF00D, 32'h0);
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    chk("mtlo_hi", hi, 32'h00000002);
    chk("mtlo_busy", 32'(busy), 32'd0);

    expect_res(32'h40000000, 32'h00000000, 5);
    issue(3'b000, 32'h80000000, 32'h80000000);
    wait_idle();
    expect_res(32'hFFFFFFFE, 32'h00000001, 5);
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();

    issue(3'b110, 32'h11111111, 32'h2);
    chk("rsvd_busy", 32'(busy), 32'd0);
    chk("rsvd_hi", hi, 32'hFFFFFFFE);
    chk("rsvd_lo", lo, 32'h00000001);

`ifdef MDU_DIV_EN
    expect_res(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    wait_idle();
    expect_res(32'h00000000, 32'h80000000, 10);
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    expect_res(32'h00000055, 32'hFFFFFFFF, 10);
    issue(3'b011, 32'h00000055, 32'h0);
    wait_idle();
    expect_res(32'h00000002, 32'h0000000E, 10);
    issue(3'b011, 32'd100, 32'd7);
    wait_idle();
    expect_res(32'h00000001, 32'hFFFFFFFD, 10);
    issue(3'b010, 32'd7, 32'hFFFFFFFE);
    wait_idle();
    expect_res(32'hFFFFFFF0, 32'hFFFFFFFF, 10);
    issue(3'b010, 32'hFFFFFFF0, 32'h0);
    wait_idle();
`else
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    chk("nodiv_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("nodiv_busy_late", 32'(busy), 32'd0);
    chk("nodiv_hi", hi, 32'hFFFFFFFE);
    chk("nodiv_lo", lo, 32'h00000001);
    expect_res(32'h00000000, 32'h00012340, 5);
    issue(3'b001, 32'h00001234, 32'h10);
    wait_idle();
`endif

    // Second start (and a move) while running must not disturb the in-flight op.
    expect_res(32'h00000000, 32'h00000100, 5);
    issue(3'b001, 32'h10, 32'h10);
    @(negedge clk);
    issue(3'b100, 32'hDEADBEEF, 32'd7);
    A = 32'h77777777; B = 32'h99999999;
    issue(3'b000, 32'h55555555, 32'h3);
    wait_idle();
    @(negedge clk);
    chk("run_ignore_hi", hi, 32'h00000000);
    chk("run_ignore_busy", 32'(busy), 32'd0);

    expect_res(32'hFFFFFFFF, 32'hFFFFFFF9, 5);
    issue(3'b000, 32'hFFFFFFF9, 32'd1);
    wait_idle();

    issue(3'b000, 32'd5, 32'd6);
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_hi", hi, 32'h0);
    chk("post_reset_lo", lo, 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Parametrised multi-cycle multiply/divide unit with HI/LO result registers, the sequential companion of the datapath ALU in the execute stage. Accepts one operation per start pulse, holds `busy` for a fixed, per-operation latency that models an iterative datapath, then commits the results to HI/LO. Also provides single-cycle direct writes to HI/LO (move-to-HI/LO). The pipeline stalls on `busy` and reads HI/LO as ordinary registers.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width; legal range ≥ 8.
- `MULT_LAT`, 5: busy cycles for multiply ops; legal range ≥ 1.
- `DIV_LAT`, 10: busy cycles for divide ops; legal range ≥ 1.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request to launch `op`; sampled on the rising edge.
- `op`, in, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x reserved.
- `A`, in, WIDTH: operand A (dividend / multiplicand / move source).
- `B`, in, WIDTH: operand B (divisor / multiplier).
- `busy`, out, 1: operation in flight; the upstream stage stalls while it is high.
- `hi`, out, WIDTH: HI register (high product / remainder).
- `lo`, out, WIDTH: LO register (low product / quotient).

## Operation
- States: IDLE, RUN. Down-counter `cnt`, width clog2(max(MULT_LAT,DIV_LAT)+1).
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU:
  - Latch `A`, `B`, `op`.
  - Load `cnt` with MULT_LAT or DIV_LAT.
  - Go to RUN.
- IDLE, `start`=1, MTHI/MTLO: write `A` to `hi`/`lo` on that edge. No RUN, `busy` stays 0.
- IDLE, reserved op: ignored; no state change.
- RUN: decrement `cnt` each edge. On the edge where `cnt`==1, write HI/LO and return to IDLE.
- `start` while in RUN: ignored. No queueing and no abort; the in-flight operation completes unchanged.
- Arithmetic uses the latched operands, so input changes during RUN have no effect.
- MULT: signed 2·WIDTH product, {hi,lo} = $signed(A)·$signed(B).
- MULTU: unsigned 2·WIDTH product, {hi,lo} = A·B.
- DIV:
  - Quotient truncates toward zero; remainder takes the sign of the dividend; lo = quotient, hi = remainder.
  - Overflow case, A = most-negative and B = −1: lo = most-negative, hi = 0.
- DIVU: lo = A/B, hi = A%B.
- Divide by zero, DIV or DIVU: lo = all ones, hi = A. `busy` still lasts DIV_LAT cycles.
- Outside a commit or move, `hi`/`lo` hold their value.

## Timing
- Reset, asynchronous, takes effect immediately: `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0.
- Reset asserted during RUN aborts the operation. No partial result is written.
- Launch sampled at edge E0: `busy`=1 from E0 until edge E0+N, with N = MULT_LAT or DIV_LAT. This is exactly N cycles high.
- New `hi`/`lo` values are visible in the same cycle `busy` falls.
- Back-to-back: `start` in the first cycle with `busy`=0 is accepted. Throughput is one op per N+1 cycles minimum.
- MTHI/MTLO latency is 1 edge; `busy` is unaffected.
- `busy` is a registered output with no combinational path from `start`.

## Configuration
- Macro `MDU_DIV_EN`.
- Defined: DIV/DIVU behave as specified above.
- Undefined:
  - No divider hardware is built; `DIV_LAT` is unused.
  - DIV/DIVU behave as reserved ops: ignored, `busy` stays 0, HI/LO unchanged.
  - MULT, MULTU, MTHI and MTLO are unaffected.

## Test plan
- Reset check:
  - Release `rst_n` → `busy`=0, `hi`=0, `lo`=0.
  - MTHI A=0x12345678 → `hi`=0x12345678 one edge later, `busy` never rises.
- MULT, defaults:
  - A=0xFFFFFFFE (−2), B=3 → `busy` high exactly 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
  - MULTU with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV:
  - A=−7 (0xFFFFFFF9), B=2 → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - A=0x80000000, B=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU by zero, A=0x55 → `lo`=0xFFFFFFFF, `hi`=0x55, `busy` high 10 cycles.
- Mid-operation events:
  - `start` with a different op/operands during RUN → ignored; the original result commits.
  - `rst_n` pulsed at RUN cycle 3 → `busy`=0 and `hi`=`lo`=0 immediately; no later commit.
- Build without `MDU_DIV_EN`, issue DIV → `busy` stays 0, HI/LO unchanged; MULTU still correct.
